// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub. The ovf signal exists only when
// SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int unsigned Width = 8
);
  logic             start;
  logic             mode;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             busy;
  logic             done;
  logic [Width-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, mode, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, mode, a, b,
`ifdef SERIAL_ADDSUB_OVF_EN
    output ovf,
`endif
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic             s_bit;
  logic             c_out;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;

  assign s_bit     = a_q[0] ^ b_q[0] ^ c_q;
  assign c_out     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign res_shift = {s_bit, res_q[WIDTH-1:1]};
  assign last_bit  = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == StIdle) begin
      if (bus.start) begin
        a_d   = bus.a;
        // Subtract as a + ~b + 1: invert b and seed the carry with mode.
        b_d   = bus.mode ? ~bus.b : bus.b;
        c_d   = bus.mode;
        cnt_d = '0;
      end
    end else begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = res_shift;
      c_d   = c_out;
      cnt_d = cnt_q + CntW'(1);
      if (last_bit) begin
        sum_d   = res_shift;
        carry_d = c_out;
        done_d  = 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
        // c_q is the carry into the MSB on this edge.
        ovf_d   = c_q ^ c_out;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    bus.busy  = (state_q == StRun);
    bus.done  = done_q;
    bus.sum   = sum_q;
    bus.carry = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    bus.ovf   = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub; expected results come from signed/unsigned
// integer arithmetic. Honours SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int unsigned  due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        sb[$];
  logic [W-1:0] last_sum;
  logic        last_carry;

  serial_addsub_if #(.Width(W)) bus ();

  serial_addsub #(.WIDTH(W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input int unsigned due);
    exp_t        e;
    longint      ua, ub, sa, sbv, r, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (m) begin
      e.sum   = W'(ua - ub);
      e.carry = (ua >= ub);
      r       = sa - sbv;
    end else begin
      e.sum   = W'(ua + ub);
      e.carry = ((ua + ub) >= (longint'(1) << W));
      r       = sa + sbv;
    end
    e.ovf = (r > lim - 1) || (r < -lim);
    e.due = due;
    return e;
  endfunction

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input bit accept);
    if (accept) sb.push_back(model(a, b, m, cyc + W + 1));
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.mode  = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.mode  = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 4 * W) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.busy && bus.done) chk("busy_and_done", 64'd1, 64'd0);
        if (bus.busy) chk("sum_hold", 64'(bus.sum), 64'(last_sum));
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("sum", 64'(bus.sum), 64'(e.sum));
            chk("carry", 64'(bus.carry), 64'(e.carry));
`ifdef SERIAL_ADDSUB_OVF_EN
            chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
            chk("latency", 64'(cyc), 64'(e.due));
            last_sum   = e.sum;
            last_carry = e.carry;
          end
        end
      end
    end
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_sum  = '0;
    last_carry = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_carry", 64'(bus.carry), 64'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    issue(8'h5A, 8'h3C, 1'b0, 1'b1); wait_done();
    issue(8'hFF, 8'h01, 1'b0, 1'b1); wait_done();
    issue(8'h10, 8'h01, 1'b1, 1'b1); wait_done();
    issue(8'h00, 8'h01, 1'b1, 1'b1); wait_done();
    issue(8'h80, 8'h01, 1'b1, 1'b1); wait_done();

    // Start while busy is ignored; back-to-back start on the done cycle.
    issue(8'h01, 8'h01, 1'b0, 1'b1);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    issue(8'hAA, 8'h55, 1'b1, 1'b0);
    wait_done();
    issue(8'h03, 8'h01, 1'b1, 1'b1);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done();

    // Reset mid-operation
    issue(8'h77, 8'h22, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    last_sum = '0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_sum", 64'(bus.sum), 64'd0);
    chk("midrst_carry", 64'(bus.carry), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'hC8, 8'h64, 1'b0, 1'b1); wait_done();

    // Random operations, with random gaps (including back-to-back)
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    n = 0;
    while (sb.size() != 0 && n < 4 * W) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor: it extends the single-bit sum/carry cell to a WIDTH-bit operation. Each clock it processes one bit, LSB first, through a single full-adder slice and a carry flip-flop. It uses a start/busy/done handshake so a controlling FSM or testbench can issue back-to-back operations. It sits beside the combinational arithmetic cells as the area-minimal datapath option.

## Interface

- WIDTH, 8: operand and result width in bits. Legal range is 2 to 64.

- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request to begin an operation. Sampled on the rising edge of clk.
- mode, input, 1: 0 = add (a+b), 1 = subtract (a−b). Sampled with start.
- a, input, WIDTH: operand A. Sampled with start.
- b, input, WIDTH: operand B. Sampled with start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: single-cycle pulse when a result becomes valid.
- sum, output, WIDTH: result register.
- carry, output, 1: final carry out. In subtract mode, 1 = no borrow.
- ovf, output, 1: signed two's-complement overflow. Present only with SERIAL_ADDSUB_OVF_EN.

## Operation

- **States:** IDLE, RUN.
  - Reset enters IDLE.
  - done is a registered flag, not a state.
- **IDLE, start=1:**
  - Latch a into shift register A.
  - Latch b into shift register B. In subtract mode, latch ~b instead.
  - Load the carry flip-flop with mode, giving carry-in 1 for subtract.
  - Clear the bit counter to 0, set busy=1, and go to RUN.
- **RUN, each edge:**
  - s = A[0] ^ B[0] ^ c.
  - c' = majority(A[0], B[0], c).
  - Shift A and B right by one.
  - Shift s into the MSB of the result shift register.
  - Increment the counter.
- **RUN, completing edge:**
  - On the edge where the counter reaches WIDTH−1, copy the completed shift value into sum and the final c' into carry.
  - On the same edge: busy=0, done=1, go to IDLE.
- **Output hold:**
  - sum, carry and ovf hold the previous result during RUN.
  - They change only on the completing edge.
  - They hold thereafter until the next completion.
- **Start while busy:** ignored entirely. Operands and mode are not re-sampled.
- **Start on the done cycle:** accepted, because the block is in IDLE. This allows back-to-back operations with no dead cycle.
- **Arithmetic:**
  - Modulo 2^WIDTH.
  - carry is the true carry out of bit WIDTH−1.
  - Subtraction is a + ~b + 1.
- **Reset mid-operation:** aborts immediately and returns to IDLE. No done pulse is produced and the partial result is discarded.

## Timing

- Reset values: busy=0, done=0, sum=0, carry=0, ovf=0, state=IDLE, counter=0.
- Reset is asserted asynchronously and deasserted on the clock; deassertion is synchronised upstream.
- Start accepted at edge E0: busy=1 after E0.
- Bits 0..WIDTH−1 are processed at edges E1..E_WIDTH.
- After E_WIDTH: done=1, busy=0, and sum/carry/ovf are valid.
- done drops after E_WIDTH+1 unless a new operation completes on that edge, which is impossible for WIDTH ≥ 2.
- Latency is WIDTH+1 edges from start to done.
- Throughput is one operation per WIDTH+1 cycles.
- busy and done are never high together.
- Counter width is clog2(WIDTH)+1 bits. The counter never wraps inside an operation.

## Configuration

- SERIAL_ADDSUB_OVF_EN defined:
  - Port ovf exists.
  - The carry into bit WIDTH−1 is captured on the edge that processes bit WIDTH−1.
  - On completion, ovf = (carry into MSB) XOR (carry out of MSB).
  - Reset value of ovf is 0.
- SERIAL_ADDSUB_OVF_EN undefined:
  - Port ovf and its flip-flops are absent.
  - All other behaviour is identical.

## Test plan

- **Add with overflow:** WIDTH=8, mode=0, a=0x5A, b=0x3C, pulse start → done exactly 9 edges later; sum=0x96, carry=0, ovf=1.
- **Add wrap:** mode=0, a=0xFF, b=0x01 → sum=0x00, carry=1, ovf=0.
- **Subtract:**
  - a=0x10, b=0x01 → sum=0x0F, carry=1.
  - a=0x00, b=0x01 → sum=0xFF, carry=0, ovf=0.
  - a=0x80, b=0x01 → sum=0x7F, carry=1, ovf=1.
- **Start while busy:** start operation 0x01+0x01; pulse start with a=0xAA at E3 → single done with sum=0x02, and sum holds its prior value until done.
- **Back-to-back:** assert start on the done cycle with 0x03−0x01 → busy rises immediately; second done gives 0x02, carry=1.
- **Reset mid-operation:** drop rst_n at E4 → busy=0, done never pulses, sum=0x00, carry=0; the next operation after release completes correctly.
